// File: rtl/mips_pc_pkg.sv
// Shared PC-path definitions: widths, reset default, FSM states and redirect-select codes.
package mips_pc_pkg;
  localparam int          ADDR_W_DEF   = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam int          PC_STEP      = 4;

  typedef enum logic {SEQ, PENDING} pc_state_e;

  typedef enum logic [1:0] {SEL_SEQ, SEL_BR, SEL_J, SEL_JR} redirect_sel_e;
endpackage

// File: rtl/pc_target_calc.sv
// Combinational branch/jump/register-jump target generation with jr > jmp > br priority.
module pc_target_calc
  import mips_pc_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic [ADDR_W-1:0] pc_plus4,
  input  logic              br_taken,
  input  logic [15:0]       br_imm,
  input  logic              jmp,
  input  logic [25:0]       jmp_index,
  input  logic              jr,
  input  logic [ADDR_W-1:0] jr_target,
  output redirect_sel_e     sel,
  output logic [ADDR_W-1:0] target
);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

  logic [ADDR_W-1:0] br_tgt;
  logic [ADDR_W-1:0] j_tgt;
  logic [ADDR_W-1:0] jr_tgt;

  // Word offset sign-extended and scaled by 4; wrap-around is intentional.
  assign br_tgt = pc_plus4 + {{(ADDR_W-18){br_imm[15]}}, br_imm, 2'b00};
  assign j_tgt  = {pc_plus4[ADDR_W-1:28], jmp_index, 2'b00};
  assign jr_tgt = jr_target & ALIGN_MASK;

  always_comb begin
    sel    = SEL_SEQ;
    target = pc_plus4;
    if (jr) begin
      sel    = SEL_JR;
      target = jr_tgt;
    end else if (jmp) begin
      sel    = SEL_J;
      target = j_tgt;
    end else if (br_taken) begin
      sel    = SEL_BR;
      target = br_tgt;
    end
  end
endmodule

// File: rtl/next_pc_unit.sv
// PC register and next-PC selection with flush/stall and optional delay slot.
// Build option: NEXT_PC_ALIGN_CHK_EN rejects misaligned jr/flush targets and pulses misalign_err.
module next_pc_unit
  import mips_pc_pkg::*;
#(
  parameter int                ADDR_W     = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(RESET_PC_DEF),
  parameter bit                DELAY_SLOT = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic [ADDR_W-1:0] flush_pc,
  input  logic              br_taken,
  input  logic [15:0]       br_imm,
  input  logic              jmp,
  input  logic [25:0]       jmp_index,
  input  logic              jr,
  input  logic [ADDR_W-1:0] jr_target,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic              redirect_pending,
  output logic              misalign_err
);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pend_target;
  logic [ADDR_W-1:0] sel_target;
  logic [ADDR_W-1:0] flush_tgt;
  pc_state_e         state;
  redirect_sel_e     sel;
  logic              jr_reject;
  logic              flush_reject;
  logic              take_redirect;

  assign pc_plus4  = pc_q + ADDR_W'(PC_STEP);
  assign flush_tgt = flush_pc & ALIGN_MASK;

  pc_target_calc #(.ADDR_W(ADDR_W)) u_calc (
    .pc_plus4  (pc_plus4),
    .br_taken  (br_taken),
    .br_imm    (br_imm),
    .jmp       (jmp),
    .jmp_index (jmp_index),
    .jr        (jr),
    .jr_target (jr_target),
    .sel       (sel),
    .target    (sel_target)
  );

`ifdef NEXT_PC_ALIGN_CHK_EN
  assign jr_reject    = (sel == SEL_JR) && (jr_target[1:0] != 2'b00);
  assign flush_reject = (flush_pc[1:0] != 2'b00);
`else
  assign jr_reject    = 1'b0;
  assign flush_reject = 1'b0;
`endif

  // A rejected jr falls back to sequential fetch rather than a lower-priority redirect.
  assign take_redirect = (sel != SEL_SEQ) && !jr_reject;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q        <= RESET_PC;
      state       <= SEQ;
      pend_target <= '0;
    end else if (flush) begin
      if (!flush_reject) pc_q <= flush_tgt;
      state       <= SEQ;
      pend_target <= '0;
    end else if (!stall) begin
      if (state == PENDING) begin
        pc_q  <= pend_target;
        state <= SEQ;
      end else if (take_redirect) begin
        if (DELAY_SLOT) begin
          pend_target <= sel_target;
          pc_q        <= pc_plus4;
          state       <= PENDING;
        end else begin
          pc_q <= sel_target;
        end
      end else begin
        pc_q <= pc_plus4;
      end
    end
  end

`ifdef NEXT_PC_ALIGN_CHK_EN
  logic err_q;
  always_ff @(posedge clk) begin
    if (rst)        err_q <= 1'b0;
    else if (flush) err_q <= flush_reject;
    else            err_q <= !stall && (state == SEQ) && jr_reject;
  end
  assign misalign_err = err_q;
`else
  assign misalign_err = 1'b0;
`endif

  assign pc               = pc_q;
  assign redirect_pending = (state == PENDING);
endmodule
